// File: rtl/panel_scanner.sv
// ---------------------------------------------------------------------------
// panel_scanner
//
// Refresh engine for a 32x32 HUB75-style LED panel at 1/16 scan. Each scan
// row drives pixel row r on the upper half and pixel row r+16 on the lower
// half. Brightness comes from binary-coded modulation: every row is shifted
// out once per bit plane (0..7) and then lit for a time proportional to the
// plane weight.
//
// Ports:
//   clk             system clock
//   rst             asynchronous, active-low reset
//   rd_addr         frame-memory read address {buffer, row[4:0], col[4:0]}
//   rd_data         pixel {blue, green, red}, valid one clk after rd_addr
//   selected_buffer buffer most recently completed by the frame writer
//   actual_buffer   buffer currently being displayed
//   r0,g0,b0        colour data for the upper half of the panel
//   r1,g1,b1        colour data for the lower half of the panel
//   row_addr        panel row select A..D
//   panel_clk       panel shift clock
//   lat             panel latch strobe
//   oe_n            panel output enable, active-low
//   frame_start     one-clk pulse in the first clk of every frame
// ---------------------------------------------------------------------------
module panel_scanner #(
    parameter int DISP_UNIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] rd_addr,
    input  logic [23:0] rd_data,
    input  logic        selected_buffer,
    output logic        actual_buffer,
    output logic        r0,
    output logic        g0,
    output logic        b0,
    output logic        r1,
    output logic        g1,
    output logic        b1,
    output logic [3:0]  row_addr,
    output logic        panel_clk,
    output logic        lat,
    output logic        oe_n,
    output logic        frame_start
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SHIFT   = 2'd1;
    localparam logic [1:0] LATCH   = 2'd2;
    localparam logic [1:0] DISPLAY = 2'd3;

    // Wide enough to hold the longest on-time (128 * DISP_UNIT) itself.
    localparam int CNT_W = $clog2(DISP_UNIT * 128 + 1);

    logic [1:0]       state;
    logic [1:0]       phase;
    logic [4:0]       col;
    logic [3:0]       row;
    logic [2:0]       plane;
    logic [CNT_W-1:0] disp_cnt;
    logic [CNT_W-1:0] disp_len;
    logic [23:0]      upper_px;
    logic [23:0]      lower_px;
    logic [23:0]      lower_live;

    assign disp_len = CNT_W'(DISP_UNIT) << plane;

    // Phase 1 of a column fetches the lower-half pixel (row r+16), every
    // other phase points at the upper-half pixel.
    assign rd_addr = {actual_buffer, (phase == 2'd1), row, col};

    // The lower pixel arrives on rd_data during phase 2; showing it straight
    // away gives the panel a full clk of data setup before panel_clk rises.
    // It is registered at the end of phase 2 so phase 3 holds the same data.
    assign lower_live = (state == SHIFT && phase == 2'd2) ? rd_data : lower_px;

    logic [7:0] up_r, up_g, up_b, lo_r, lo_g, lo_b;
    assign up_r = upper_px[7:0];
    assign up_g = upper_px[15:8];
    assign up_b = upper_px[23:16];
    assign lo_r = lower_live[7:0];
    assign lo_g = lower_live[15:8];
    assign lo_b = lower_live[23:16];

    assign r0 = up_r[plane];
    assign g0 = up_g[plane];
    assign b0 = up_b[plane];
    assign r1 = lo_r[plane];
    assign g1 = lo_g[plane];
    assign b1 = lo_b[plane];

    // Panel strobes decode directly from the state and phase flops. The last
    // DISPLAY clk (disp_cnt == disp_len) is a blanking clk with the LEDs off
    // so the next shift never overlaps a lit row.
    assign panel_clk = (state == SHIFT) && (phase == 2'd3);
    assign lat       = (state == LATCH);
    assign oe_n      = !((state == DISPLAY) && (disp_cnt != disp_len));

    // Scan sequencer: shift one row of one bit plane, latch it, light it,
    // then step plane, row and (at the end of the frame) the display buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            phase         <= 2'd0;
            col           <= 5'd0;
            row           <= 4'd0;
            plane         <= 3'd0;
            disp_cnt      <= '0;
            upper_px      <= 24'd0;
            lower_px      <= 24'd0;
            actual_buffer <= 1'b0;
            row_addr      <= 4'd0;
            frame_start   <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            case (state)
                IDLE: begin
                    state       <= SHIFT;
                    phase       <= 2'd0;
                    col         <= 5'd0;
                    row         <= 4'd0;
                    plane       <= 3'd0;
                    frame_start <= 1'b1;
                end
                SHIFT: begin
                    phase <= phase + 2'd1;
                    if (phase == 2'd1) begin
                        upper_px <= rd_data;
                    end
                    if (phase == 2'd2) begin
                        lower_px <= rd_data;
                    end
                    if (phase == 2'd3) begin
                        col <= col + 5'd1;
                        if (col == 5'd31) begin
                            state    <= LATCH;
                            row_addr <= row;
                        end
                    end
                end
                LATCH: begin
                    state    <= DISPLAY;
                    disp_cnt <= '0;
                end
                DISPLAY: begin
                    if (disp_cnt == disp_len) begin
                        state    <= SHIFT;
                        disp_cnt <= '0;
                        plane    <= plane + 3'd1;
                        if (plane == 3'd7) begin
                            row <= row + 4'd1;
                            if (row == 4'd15) begin
                                actual_buffer <= selected_buffer;
                                frame_start   <= 1'b1;
                            end
                        end
                    end else begin
                        disp_cnt <= disp_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_panel_scanner.sv
// ---------------------------------------------------------------------------
// tb_panel_scanner
//
// Directed testbench for panel_scanner with the default DISP_UNIT of 8.
// The frame memory holds a single red pixel at buffer 0, row 0, col 5;
// every other location reads as black.
// ---------------------------------------------------------------------------
module tb_panel_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] rd_addr;
    logic [23:0] rd_data = 24'd0;
    logic        selected_buffer = 1'b0;
    logic        actual_buffer;
    logic        r0, g0, b0, r1, g1, b1;
    logic [3:0]  row_addr;
    logic        panel_clk;
    logic        lat;
    logic        oe_n;
    logic        frame_start;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int fs_cyc = 0;

    panel_scanner #(.DISP_UNIT(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .selected_buffer (selected_buffer),
        .actual_buffer   (actual_buffer),
        .r0              (r0),
        .g0              (g0),
        .b0              (b0),
        .r1              (r1),
        .g1              (g1),
        .b1              (b1),
        .row_addr        (row_addr),
        .panel_clk       (panel_clk),
        .lat             (lat),
        .oe_n            (oe_n),
        .frame_start     (frame_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] mem_pixel(input logic [10:0] a);
        return (a == 11'h005) ? 24'h0000FF : 24'h000000;
    endfunction

    // Synchronous frame memory: one clk of read latency.
    always @(posedge clk) rd_data <= mem_pixel(rd_addr);

    // Every output at its reset value; returns number of deviations.
    function automatic int reset_deviations();
        int n = 0;
        if (rd_addr !== 11'd0) n++;
        if ({r0, g0, b0, r1, g1, b1} !== 6'd0) n++;
        if (row_addr !== 4'd0) n++;
        if (panel_clk !== 1'b0) n++;
        if (lat !== 1'b0) n++;
        if (oe_n !== 1'b1) n++;
        if (frame_start !== 1'b0) n++;
        if (actual_buffer !== 1'b0) n++;
        return n;
    endfunction

    // Called at the negedge of the first SHIFT clk of a plane; returns at
    // the negedge of the first SHIFT clk of the following plane.
    task automatic observe_plane(input int p, input logic [3:0] r,
                                 input logic ab, input logic fs,
                                 input logic red);
        int bad_addr = 0;
        int bad_color = 0;
        int bad_strobe = 0;
        int bad_disp = 0;
        int rises = 0;
        int low = 0;
        logic prev_pclk = 1'b0;
        logic [4:0] c;
        logic exp_r0;
        checks++;
        if (frame_start !== fs) begin
            errors++;
            $display("[TB] FAIL frame_start p%0d r%0d: got %b want %b", p, r, frame_start, fs);
        end
        for (int k = 0; k < 128; k++) begin
            if (k > 0) @(negedge clk);
            c = 5'(k / 4);
            if ((k % 4) == 0 && rd_addr !== {ab, 1'b0, r, c}) bad_addr++;
            if ((k % 4) == 1 && rd_addr !== {ab, 1'b1, r, c}) bad_addr++;
            if (oe_n !== 1'b1 || lat !== 1'b0) bad_strobe++;
            if (panel_clk !== ((k % 4) == 3)) bad_strobe++;
            if (panel_clk === 1'b1 && prev_pclk === 1'b0) begin
                rises++;
                exp_r0 = red && (c == 5'd5);
                if (r0 !== exp_r0 || {g0, b0, r1, g1, b1} !== 5'd0) bad_color++;
            end
            prev_pclk = panel_clk;
        end
        checks++;
        if (bad_addr != 0) begin
            errors++;
            $display("[TB] FAIL rd_addr p%0d r%0d: %0d bad fetches, want 0", p, r, bad_addr);
        end
        checks++;
        if (rises != 32) begin
            errors++;
            $display("[TB] FAIL panel_clk edges p%0d r%0d: got %0d want 32", p, r, rises);
        end
        checks++;
        if (bad_color != 0) begin
            errors++;
            $display("[TB] FAIL colour p%0d r%0d: %0d bad columns, want 0", p, r, bad_color);
        end
        checks++;
        if (bad_strobe != 0) begin
            errors++;
            $display("[TB] FAIL shift strobes p%0d r%0d: %0d bad clks, want 0", p, r, bad_strobe);
        end
        @(negedge clk);
        checks++;
        if (lat !== 1'b1 || oe_n !== 1'b1 || row_addr !== r) begin
            errors++;
            $display("[TB] FAIL latch p%0d: lat=%b oe_n=%b row_addr=%0d want 1 1 %0d",
                     p, lat, oe_n, row_addr, r);
        end
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (oe_n !== 1'b0) break;
            low++;
            if (lat !== 1'b0 || panel_clk !== 1'b0) bad_disp++;
        end
        checks++;
        if (low != (8 << p) || bad_disp != 0) begin
            errors++;
            $display("[TB] FAIL display p%0d: oe_n low %0d clks (%0d bad), want %0d (0 bad)",
                     p, low, bad_disp, 8 << p);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        int dev;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        dev = reset_deviations();
        checks++;
        if (dev != 0) begin
            errors++;
            $display("[TB] FAIL reset outputs: %0d deviations, want 0", dev);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (frame_start !== 1'b0 || oe_n !== 1'b1) begin
            errors++;
            $display("[TB] FAIL idle clk: frame_start=%b oe_n=%b want 0 1", frame_start, oe_n);
        end
        @(negedge clk);
        fs_cyc = cyc;
    endtask

    task automatic test_row0_planes();
        for (int p = 0; p < 8; p++) observe_plane(p, 4'd0, 1'b0, p == 0, 1'b1);
    endtask

    // Runs rows 1..15, toggling selected_buffer 1 -> 0 -> 1 mid-frame; the
    // value present at the frame end (1) must be the one adopted.
    task automatic test_buffer_switch();
        int lat_idx = 0;
        int bad_row = 0;
        int bad_ab = 0;
        bit found = 0;
        logic [3:0] exp_row;
        for (int i = 0; i < 60000; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                found = 1;
                break;
            end
            if (actual_buffer !== 1'b0 || rd_addr[10] !== 1'b0) bad_ab++;
            if (lat === 1'b1) begin
                exp_row = 4'(1 + lat_idx / 8);
                if (row_addr !== exp_row) bad_row++;
                if (lat_idx % 8 == 0) begin
                    if (exp_row == 4'd7)  selected_buffer = 1'b1;
                    if (exp_row == 4'd10) selected_buffer = 1'b0;
                    if (exp_row == 4'd12) selected_buffer = 1'b1;
                end
                lat_idx++;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL frame end: no frame_start within 60000 clks");
        end
        checks++;
        if (lat_idx != 120 || bad_row != 0) begin
            errors++;
            $display("[TB] FAIL row sequence: %0d lats (%0d bad rows), want 120 (0)", lat_idx, bad_row);
        end
        checks++;
        if (bad_ab != 0) begin
            errors++;
            $display("[TB] FAIL mid-frame buffer: %0d clks off buffer 0, want 0", bad_ab);
        end
        checks++;
        if (actual_buffer !== 1'b1 || rd_addr !== 11'h400) begin
            errors++;
            $display("[TB] FAIL buffer swap: actual_buffer=%b rd_addr=%h want 1 400",
                     actual_buffer, rd_addr);
        end
        checks++;
        if (cyc - fs_cyc != 49280) begin
            errors++;
            $display("[TB] FAIL frame period: got %0d want 49280", cyc - fs_cyc);
        end
    endtask

    task automatic test_row_wrap();
        observe_plane(0, 4'd0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_display();
        int lat9 = 0;
        int dev;
        int bad_hold = 0;
        int wait_lat = 0;
        bit found = 0;
        for (int i = 0; i < 40000; i++) begin
            @(negedge clk);
            if (lat === 1'b1 && row_addr === 4'd9) begin
                lat9++;
                if (lat9 == 4) begin
                    found = 1;
                    break;
                end
            end
        end
        repeat (5) @(negedge clk);
        checks++;
        if (!found || oe_n !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reach row 9 plane 3 display: found=%0b oe_n=%b want 1 0", found, oe_n);
        end
        rst = 1'b0;
        #1;
        dev = reset_deviations();
        checks++;
        if (dev != 0) begin
            errors++;
            $display("[TB] FAIL async reset: %0d deviations, want 0", dev);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (lat !== 1'b0 || oe_n !== 1'b1) bad_hold++;
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (frame_start !== 1'b1 || rd_addr !== 11'h000 || bad_hold != 0) begin
            errors++;
            $display("[TB] FAIL restart: frame_start=%b rd_addr=%h hold_bad=%0d want 1 000 0",
                     frame_start, rd_addr, bad_hold);
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            wait_lat++;
            if (lat === 1'b1) break;
        end
        checks++;
        if (wait_lat != 128 || row_addr !== 4'd0) begin
            errors++;
            $display("[TB] FAIL first lat after reset: after %0d clks row_addr=%0d want 128 0",
                     wait_lat, row_addr);
        end
    endtask

    initial begin
        test_reset();
        test_row0_planes();
        test_buffer_switch();
        test_row_wrap();
        test_reset_mid_display();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/panel_scanner.md
PANEL_SCANNER -- requirements
Module: panel_scanner

Interface
REQ-001 SHALL have parameter DISP_UNIT, default 8, giving the oe_n-low clk cycles per unit of bit-plane weight.
REQ-002 SHALL have port clk  input  1  system clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rd_addr  output  11  frame-memory read address {buffer, row[4:0], col[4:0]}.
REQ-005 SHALL have port rd_data  input  24  pixel {blue[7:0], green[7:0], red[7:0]}, valid exactly 1 clk after rd_addr.
REQ-006 SHALL have port selected_buffer  input  1  buffer most recently completed by the frame writer.
REQ-007 SHALL have port actual_buffer  output  1  buffer currently being displayed.
REQ-008 SHALL have ports r0, g0, b0, r1, g1, b1  output  1 each  panel color data, upper and lower half.
REQ-009 SHALL have port row_addr  output  4  panel row select A..D.
REQ-010 SHALL have port panel_clk  output  1  panel shift clock.
REQ-011 SHALL have port lat  output  1  panel latch strobe.
REQ-012 SHALL have port oe_n  output  1  panel output enable, active-low.
REQ-013 SHALL have port frame_start  output  1  1-clk pulse when a new frame begins.

Function
REQ-014 SHALL drive a 32x32 panel at 1/16 scan: scan row r (0..15) pairs pixel row r (upper, r0/g0/b0) with pixel row r+16 (lower, r1/g1/b1).
REQ-015 SHALL implement states IDLE, SHIFT, LATCH, DISPLAY.
REQ-016 IDLE SHALL last exactly 1 clk after reset release, then enter SHIFT with row=0, plane=0, col=0, and pulse frame_start.
REQ-017 SHALL use exactly 4 clk phases per column in SHIFT:
- P0: rd_addr={actual_buffer, r, col}.
- P1: rd_addr={actual_buffer, r+16, col}; capture upper pixel.
- P2: capture lower pixel; drive r0=R_up[plane], g0=G_up[plane], b0=B_up[plane], r1/g1/b1 likewise from the lower pixel; panel_clk=0.
- P3: panel_clk=1, data held.
REQ-018 SHALL shift columns 0..31 in order, so SHIFT lasts exactly 128 clk.
REQ-019 After col 31 P3, SHALL wrap col to 0 and enter LATCH.
REQ-020 LATCH SHALL last 1 clk with lat=1 and oe_n=1; row_addr SHALL update to the current r in this cycle.
REQ-021 DISPLAY SHALL hold oe_n=0 for exactly (1<<plane)*DISP_UNIT clk, with lat=0 and panel_clk=0.
REQ-022 oe_n SHALL be 1 in every state other than DISPLAY.
REQ-023 On DISPLAY exit, the scan counters SHALL advance:
- plane<7: plane+1, same row.
- plane=7, row<15: plane=0, row+1.
- plane=7, row=15: plane=0, row=0; frame end.
REQ-024 DISPLAY SHALL always be followed by SHIFT.
REQ-025 At frame end, SHALL load actual_buffer<=selected_buffer in the same clk as the transition to SHIFT, and pulse frame_start in that clk.
REQ-026 actual_buffer SHALL change only at a frame end, never mid-frame.
REQ-027 rd_addr[10] SHALL equal actual_buffer.
REQ-028 A selected_buffer toggle mid-frame SHALL have no effect until the next frame end; multiple toggles SHALL collapse to the value sampled at frame end.
REQ-029 Frame period SHALL be 1 + 16*(8*130 + 255*DISP_UNIT) clk for the first frame, and 16*(8*130 + 255*DISP_UNIT) clk thereafter.
- Default (DISP_UNIT=8): 49280 clk.
REQ-030 Counter widths: col 5 bits, row 4 bits, plane 3 bits, display counter at least 11 bits for DISP_UNIT up to 8.

Reset
REQ-031 On rst low, SHALL asynchronously force state=IDLE, row/col/plane=0, actual_buffer=0, rd_addr=0, r0..b1=0, row_addr=0, panel_clk=0, lat=0, oe_n=1, frame_start=0.
REQ-032 Reset asserted mid-operation SHALL abort the current shift or display with no further lat pulse.
REQ-033 After reset release, scanning SHALL restart per REQ-016.

Verification
REQ-034 Memory model returns {B,G,R}=addr-derived values; after reset -> rd_addr sequence starts 0x000, 0x200, 0x001, 0x201, ..., 32 panel_clk rising edges, then one lat pulse, row_addr=0.
REQ-035 Pixel (row 0, col 5) = 0x0000FF (red=255), rest 0 -> r0=1 at col 5 for all planes 0..7, g0/b0/r1/g1/b1 never 1.
REQ-036 DISP_UNIT=8 -> oe_n-low widths 8, 16, 32, ..., 1024 clk for planes 0..7; oe_n high during every SHIFT and LATCH.
REQ-037 selected_buffer toggled to 1 during row 7 -> actual_buffer stays 0 until the frame end, then becomes 1 coincident with frame_start; next rd_addr=0x400.
REQ-038 rst asserted during DISPLAY of row 9 plane 3 -> oe_n=1 and all outputs at reset values immediately; after release, first lat pulse occurs with row_addr=0.
REQ-039 Row wrap check: after row 15 plane 7 DISPLAY -> row_addr returns to 0 at the next lat; frame_start spacing is 49280 clk.
